// File: rtl/recv_pkg.sv
// Shared types, widths and helpers for the receive-side sequencer.
package recv_pkg;

    localparam int SEG_W  = 16;
    localparam int TXID_W = 8;
    localparam int AUX_W  = 8;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_SCAN,
        S_CLOSE
    } state_t;

    // Segments per group actually tracked: at least 1, never beyond the bitmap depth.
    function automatic logic [SEG_W-1:0] eff_max(input logic [SEG_W-1:0] seg_max,
                                                 input logic [SEG_W-1:0] cap);
        logic [SEG_W-1:0] m;
        m = (seg_max == '0) ? SEG_W'(1) : seg_max;
        return (m > cap) ? cap : m;
    endfunction

endpackage

// File: rtl/recv_control_sat_counter16.sv
// 16-bit counter that adds n when enabled and sticks at all-ones.
module sat_counter16
    import recv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] n,
    output logic [15:0] count
);

    logic [16:0] sum;

    assign sum = {1'b0, count} + {1'b0, n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= sum[16] ? CNT_MAX : sum[15:0];
    end

endmodule

// File: rtl/recv_control.sv
// Receive sequencer: keeps the first good copy of each segment per aux group, closes groups
// with a bitmap scan. Optional idle-timeout close is compiled in with RECV_TIMEOUT_EN.
module recv_control
    import recv_pkg::*;
#(
    parameter int unsigned MAX_SEG        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 125000000
) (
    input  logic              clk125MHz,
    input  logic              RST,
    input  logic [SEG_W-1:0]  segment_num_max,
    input  logic [TXID_W-1:0] redundancy,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              frame_crc_ok,
    input  logic [SEG_W-1:0]  rx_segment_num,
    input  logic [TXID_W-1:0] rx_txid,
    input  logic [AUX_W-1:0]  rx_aux,
    output logic              accept,
    output logic [SEG_W-1:0]  accept_segment_num,
    output logic [AUX_W-1:0]  accept_aux,
    output logic              group_done,
    output logic              group_complete,
    output logic [15:0]       dup_count,
    output logic [15:0]       lost_count,
    output logic [15:0]       err_count
);

    localparam int IDX_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    state_t              state, state_n;
    logic [MAX_SEG-1:0]  bitmap, bitmap_n;
    logic [AUX_W-1:0]    cur_aux, cur_aux_n;
    logic [SEG_W-1:0]    pend_seg, pend_seg_n;
    logic [AUX_W-1:0]    pend_aux, pend_aux_n;
    logic                pend_vld, pend_vld_n;
    logic [SEG_W-1:0]    scan_idx, scan_idx_n;
    logic [SEG_W-1:0]    zeros, zeros_n;
    logic [SEG_W-1:0]    cfg_max, cfg_max_n;
    logic [TXID_W-1:0]   cfg_red, cfg_red_n;
    logic                accept_n, done_n, complete_n;
    logic [SEG_W-1:0]    acc_seg_n;
    logic [AUX_W-1:0]    acc_aux_n;
    logic                dup_inc, err_inc, lost_inc;
    logic                hs, bad;
    logic [SEG_W-1:0]    live_max, chk_max;
    logic [TXID_W-1:0]   chk_red;
    logic [IDX_W-1:0]    rx_idx;
`ifdef RECV_TIMEOUT_EN
    logic [31:0]         idle_cnt, idle_n;
`endif

    assign frame_ready = (state == S_IDLE) || (state == S_OPEN);
    assign hs          = frame_valid & frame_ready;
    assign rx_idx      = rx_segment_num[IDX_W-1:0];
    assign live_max    = eff_max(segment_num_max, SEG_W'(MAX_SEG));
    // Before a group opens the live switch settings apply; afterwards the latched ones.
    assign chk_max     = (state == S_IDLE) ? live_max : cfg_max;
    assign chk_red     = (state == S_IDLE) ? redundancy : cfg_red;
    assign bad = !frame_crc_ok || (rx_segment_num >= chk_max) ||
                 (rx_txid == '0) || (rx_txid > chk_red);

    always_comb begin
        state_n    = state;
        bitmap_n   = bitmap;
        cur_aux_n  = cur_aux;
        pend_seg_n = pend_seg;
        pend_aux_n = pend_aux;
        pend_vld_n = pend_vld;
        scan_idx_n = scan_idx;
        zeros_n    = zeros;
        cfg_max_n  = cfg_max;
        cfg_red_n  = cfg_red;
        accept_n   = 1'b0;
        acc_seg_n  = accept_segment_num;
        acc_aux_n  = accept_aux;
        done_n     = 1'b0;
        complete_n = group_complete;
        dup_inc    = 1'b0;
        err_inc    = 1'b0;
        lost_inc   = 1'b0;
`ifdef RECV_TIMEOUT_EN
        idle_n     = '0;
`endif
        case (state)
            S_IDLE: begin
                if (hs) begin
                    if (bad) begin
                        err_inc = 1'b1;
                    end else begin
                        cfg_max_n        = live_max;
                        cfg_red_n        = redundancy;
                        cur_aux_n        = rx_aux;
                        bitmap_n[rx_idx] = 1'b1;
                        accept_n         = 1'b1;
                        acc_seg_n        = rx_segment_num;
                        acc_aux_n        = rx_aux;
                        state_n          = S_OPEN;
                    end
                end
            end
            S_OPEN: begin
                if (hs) begin
                    if (bad) begin
                        err_inc = 1'b1;
                    end else if (rx_aux == cur_aux) begin
                        if (bitmap[rx_idx]) begin
                            dup_inc = 1'b1;
                        end else begin
                            bitmap_n[rx_idx] = 1'b1;
                            accept_n         = 1'b1;
                            acc_seg_n        = rx_segment_num;
                            acc_aux_n        = rx_aux;
                        end
                    end else begin
                        pend_seg_n = rx_segment_num;
                        pend_aux_n = rx_aux;
                        pend_vld_n = 1'b1;
                        scan_idx_n = '0;
                        zeros_n    = '0;
                        state_n    = S_SCAN;
                    end
                end
`ifdef RECV_TIMEOUT_EN
                else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    pend_vld_n = 1'b0;
                    scan_idx_n = '0;
                    zeros_n    = '0;
                    state_n    = S_SCAN;
                end else begin
                    idle_n = idle_cnt + 32'd1;
                end
`endif
            end
            S_SCAN: begin
                zeros_n = zeros + {{(SEG_W-1){1'b0}}, ~bitmap[scan_idx[IDX_W-1:0]]};
                if (scan_idx == cfg_max - SEG_W'(1)) begin
                    lost_inc   = 1'b1;
                    done_n     = 1'b1;
                    complete_n = (zeros_n == '0);
                    state_n    = S_CLOSE;
                end else begin
                    scan_idx_n = scan_idx + SEG_W'(1);
                end
            end
            S_CLOSE: begin
                bitmap_n = '0;
                if (pend_vld) begin
                    cfg_max_n                      = live_max;
                    cfg_red_n                      = redundancy;
                    cur_aux_n                      = pend_aux;
                    bitmap_n[pend_seg[IDX_W-1:0]]  = 1'b1;
                    accept_n                       = 1'b1;
                    acc_seg_n                      = pend_seg;
                    acc_aux_n                      = pend_aux;
                    pend_vld_n                     = 1'b0;
                    state_n                        = S_OPEN;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk125MHz or posedge RST) begin
        if (RST) begin
            state              <= S_IDLE;
            bitmap             <= '0;
            cur_aux            <= '0;
            pend_seg           <= '0;
            pend_aux           <= '0;
            pend_vld           <= 1'b0;
            scan_idx           <= '0;
            zeros              <= '0;
            cfg_max            <= '0;
            cfg_red            <= '0;
            accept             <= 1'b0;
            accept_segment_num <= '0;
            accept_aux         <= '0;
            group_done         <= 1'b0;
            group_complete     <= 1'b0;
        end else begin
            state              <= state_n;
            bitmap             <= bitmap_n;
            cur_aux            <= cur_aux_n;
            pend_seg           <= pend_seg_n;
            pend_aux           <= pend_aux_n;
            pend_vld           <= pend_vld_n;
            scan_idx           <= scan_idx_n;
            zeros              <= zeros_n;
            cfg_max            <= cfg_max_n;
            cfg_red            <= cfg_red_n;
            accept             <= accept_n;
            accept_segment_num <= acc_seg_n;
            accept_aux         <= acc_aux_n;
            group_done         <= done_n;
            group_complete     <= complete_n;
        end
    end

`ifdef RECV_TIMEOUT_EN
    always_ff @(posedge clk125MHz or posedge RST) begin
        if (RST)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_n;
    end
`endif

    sat_counter16 u_dup (
        .clk   (clk125MHz),
        .rst   (RST),
        .en    (dup_inc),
        .n     (16'd1),
        .count (dup_count)
    );

    sat_counter16 u_lost (
        .clk   (clk125MHz),
        .rst   (RST),
        .en    (lost_inc),
        .n     (zeros_n),
        .count (lost_count)
    );

    sat_counter16 u_err (
        .clk   (clk125MHz),
        .rst   (RST),
        .en    (err_inc),
        .n     (16'd1),
        .count (err_count)
    );

endmodule

// File: tb/tb_recv_control.sv
// Directed self-checking bench for recv_control (4 segments per group, 3 copies per segment).
module tb_recv_control;
    import recv_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SEG_W-1:0]  segment_num_max = 16'd4;
    logic [TXID_W-1:0] redundancy = 8'd3;
    logic              frame_valid = 1'b0;
    logic              frame_ready;
    logic              frame_crc_ok = 1'b1;
    logic [SEG_W-1:0]  rx_segment_num = '0;
    logic [TXID_W-1:0] rx_txid = '0;
    logic [AUX_W-1:0]  rx_aux = '0;
    logic              accept;
    logic [SEG_W-1:0]  accept_segment_num;
    logic [AUX_W-1:0]  accept_aux;
    logic              group_done;
    logic              group_complete;
    logic [15:0]       dup_count;
    logic [15:0]       lost_count;
    logic [15:0]       err_count;

    int compared   = 0;
    int mismatched = 0;

    always #4 clk = ~clk;

    recv_control #(
        .MAX_SEG        (16),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk125MHz          (clk),
        .RST                (rst),
        .segment_num_max    (segment_num_max),
        .redundancy         (redundancy),
        .frame_valid        (frame_valid),
        .frame_ready        (frame_ready),
        .frame_crc_ok       (frame_crc_ok),
        .rx_segment_num     (rx_segment_num),
        .rx_txid            (rx_txid),
        .rx_aux             (rx_aux),
        .accept             (accept),
        .accept_segment_num (accept_segment_num),
        .accept_aux         (accept_aux),
        .group_done         (group_done),
        .group_complete     (group_complete),
        .dup_count          (dup_count),
        .lost_count         (lost_count),
        .err_count          (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one header and returns 1 time unit after the handshake edge.
    task automatic send(input int seg, input int txid, input int aux, input logic crc);
        int waited;
        @(negedge clk);
        rx_segment_num = SEG_W'(seg);
        rx_txid        = TXID_W'(txid);
        rx_aux         = AUX_W'(aux);
        frame_crc_ok   = crc;
        frame_valid    = 1'b1;
        waited = 0;
        while (!frame_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic check_close(input string tag, input logic complete, input int lost,
                               input int seg, input int aux);
        check({tag, "_no_accept_t1"}, {31'd0, accept}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, group_done}, 32'd1);
        check({tag, "_complete"}, {31'd0, group_complete}, {31'd0, complete});
        check({tag, "_lost"}, {16'd0, lost_count}, 32'(lost));
        check({tag, "_ready_low"}, {31'd0, frame_ready}, 32'd0);
        check({tag, "_no_accept_close"}, {31'd0, accept}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, group_done}, 32'd0);
        check({tag, "_accept"}, {31'd0, accept}, 32'd1);
        check({tag, "_acc_seg"}, {16'd0, accept_segment_num}, 32'(seg));
        check({tag, "_acc_aux"}, {24'd0, accept_aux}, 32'(aux));
        check({tag, "_ready_back"}, {31'd0, frame_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, frame_ready}, 32'd1);
        check("rst_accept", {31'd0, accept}, 32'd0);
        check("rst_done", {31'd0, group_done}, 32'd0);
        check("rst_counts", {dup_count, lost_count ^ err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Group 0: three copies of each of 4 segments; only copy 1 is accepted.
        for (int t = 1; t <= 3; t++) begin
            for (int s = 0; s < 4; s++) begin
                send(s, t, 0, 1'b1);
                check($sformatf("g0_accept_t%0d_s%0d", t, s), {31'd0, accept}, (t == 1) ? 32'd1 : 32'd0);
                if (t == 1) check($sformatf("g0_seg_s%0d", s), {16'd0, accept_segment_num}, 32'(s));
            end
        end
        check("g0_dup", {16'd0, dup_count}, 32'd8);

        send(0, 1, 1, 1'b1);
        check_close("g0", 1'b1, 0, 0, 1);

        // Group 1 misses segment 2.
        send(1, 1, 1, 1'b1);
        check("g1_s1_accept", {31'd0, accept}, 32'd1);
        send(3, 2, 1, 1'b1);
        check("g1_s3_accept", {31'd0, accept}, 32'd1);
        send(0, 1, 2, 1'b1);
        check_close("g1", 1'b0, 1, 0, 2);

        // Rejections inside group 2.
        send(1, 1, 2, 1'b0);
        check("err_crc_accept", {31'd0, accept}, 32'd0);
        send(4, 1, 2, 1'b1);
        check("err_range_accept", {31'd0, accept}, 32'd0);
        send(1, 0, 2, 1'b1);
        check("err_txid0_accept", {31'd0, accept}, 32'd0);
        send(1, 4, 9, 1'b1);
        check("err_txid4_state", {31'd0, frame_ready}, 32'd1);
        check("err_count", {16'd0, err_count}, 32'd4);
        send(1, 3, 2, 1'b1);
        check("g2_s1_accept", {31'd0, accept}, 32'd1);
        check("g2_s1_aux", {24'd0, accept_aux}, 32'd2);
        check("g2_dup_unchanged", {16'd0, dup_count}, 32'd8);

        // Group 2 closes with 2 missing, then group 255 fills and wraps to 0.
        send(0, 1, 255, 1'b1);
        check_close("g2", 1'b0, 3, 0, 255);
        for (int s = 1; s < 4; s++) begin
            send(s, 1, 255, 1'b1);
            check($sformatf("g255_accept_s%0d", s), {31'd0, accept}, 32'd1);
        end
        send(2, 1, 0, 1'b1);
        check_close("wrap", 1'b1, 3, 2, 0);

        // Reset in the middle of a scan.
        send(0, 1, 1, 1'b1);
        @(posedge clk);
        #1;
        check("scan_ready_low", {31'd0, frame_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, frame_ready}, 32'd1);
        check("mid_rst_accept", {31'd0, accept}, 32'd0);
        check("mid_rst_acc_fields", {8'd0, accept_segment_num, accept_aux}, 32'd0);
        check("mid_rst_counts", {dup_count, lost_count | err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_no_done_%0d", i), {31'd0, group_done}, 32'd0);
        end
        send(3, 1, 7, 1'b1);
        check("fresh_accept", {31'd0, accept}, 32'd1);
        check("fresh_aux", {24'd0, accept_aux}, 32'd7);
        send(0, 2, 7, 1'b1);
        check("fresh_s0_accept", {31'd0, accept}, 32'd1);
        check("fresh_lost", {16'd0, lost_count}, 32'd0);

`ifdef RECV_TIMEOUT_EN
        begin
            int waited = 0;
            while (!group_done && waited < 300) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("to_done", {31'd0, group_done}, 32'd1);
            check("to_window", (waited >= 100 && waited <= 110) ? 32'd1 : 32'd0, 32'd1);
            check("to_lost", {16'd0, lost_count}, 32'd2);
            check("to_complete", {31'd0, group_complete}, 32'd0);
            @(posedge clk);
            #1;
            check("to_no_accept", {31'd0, accept}, 32'd0);
            check("to_idle_ready", {31'd0, frame_ready}, 32'd1);
            send(1, 1, 7, 1'b1);
            check("to_reopen_accept", {31'd0, accept}, 32'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
